// File: rtl/sector_pingpong_buf.sv
// Two-bank ping-pong sector buffer: the writer fills one bank with auto-incrementing
// addresses while the reader drains the other through a registered valid/ready stream.
//
// state    | meaning
// RD_IDLE  | waiting for the read bank to be committed
// RD_FETCH | RAM read of rd_ptr in flight, rd_data loads at the next edge
// RD_VALID | rd_data presented; advances one word per accepted cycle
module sector_pingpong_buf #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_abort,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_last,
  output logic [1:0]           banks_full
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_VALID} rd_state_t;

  rd_state_t            rd_state, rd_state_nxt;
  logic [1:0]           full, full_set, full_clr;
  logic                 wr_bank, rd_bank;
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr, rd_addr;
  logic                 wr_fire, wr_commit;
  logic                 rd_load, rd_adv, rd_release, rd_at_last;

  // Flattened storage: bank select is the address MSB.
  logic [DATA_BITS-1:0] mem [2*DEPTH];

  assign wr_ready   = !full[wr_bank];
  assign wr_fire    = wr_valid && wr_ready && !wr_abort;
  assign wr_commit  = wr_fire && (&wr_ptr);
  assign rd_at_last = &rd_ptr;
  assign rd_valid   = (rd_state == RD_VALID);
  assign rd_last    = rd_valid && rd_at_last;
  assign full_set   = {wr_commit & wr_bank, wr_commit & ~wr_bank};
  assign full_clr   = {rd_release & rd_bank, rd_release & ~rd_bank};
  assign banks_full = {1'b0, full[0]} + {1'b0, full[1]};

  always_comb begin
    rd_state_nxt = rd_state;
    rd_load      = 1'b0;
    rd_adv       = 1'b0;
    rd_release   = 1'b0;
    rd_addr      = rd_ptr;
    case (rd_state)
      RD_IDLE:  if (full[rd_bank]) rd_state_nxt = RD_FETCH;
      RD_FETCH: begin
        rd_state_nxt = RD_VALID;
        rd_load      = 1'b1;
      end
      RD_VALID: if (rd_ready) begin
        if (rd_at_last) begin
          rd_release   = 1'b1;
          rd_state_nxt = RD_IDLE;
        end else begin
          // Prefetch the next word so an always-ready consumer gets one word per cycle.
          rd_adv  = 1'b1;
          rd_load = 1'b1;
          rd_addr = rd_ptr + 1'b1;
        end
      end
      default:  rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      full     <= (full | full_set) & ~full_clr;
      if (wr_abort) begin
        wr_ptr <= '0;
      end else if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_commit) wr_bank <= ~wr_bank;
      end
      if (rd_release) begin
        rd_bank <= ~rd_bank;
        rd_ptr  <= '0;
      end else if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (rd_load) rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

  // Full flags give each side exclusive bank ownership, so no read/write collision handling.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem[{wr_bank, wr_ptr}] <= wr_data;
  end

endmodule

// File: tb/tb_sector_pingpong_buf.sv
// Directed bench for sector_pingpong_buf: fill/drain, backpressure, abort, reset and
// same-cycle commit/release, all against hand-computed data patterns.
module tb_sector_pingpong_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       wr_abort;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_last;
  logic [1:0] banks_full;

  int n_vec = 0;
  int n_err = 0;
  int rd_cycles;
  logic [7:0] wr_q[$];
  logic [7:0] exp_q[$];

  sector_pingpong_buf #(.ADDR_BITS(9), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_abort(wr_abort),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .banks_full(banks_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_abort = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Push wr_q into the DUT; a word is consumed when wr_ready is seen at the negedge.
  task automatic write_q(input string tag);
    int budget = 4000;
    while (wr_q.size() > 0 && budget > 0) begin
      wr_valid = 1'b1;
      wr_data  = wr_q[0];
      if (wr_ready) void'(wr_q.pop_front());
      @(negedge clk);
      budget--;
    end
    wr_valid = 1'b0;
    check({tag, "_wr_left"}, wr_q.size(), 0);
  endtask

  // Drain exp_q; tog=1 drives rd_ready 1,0,1,0... and checks rd_data holds while stalled.
  task automatic read_q(input bit tog, input string tag);
    int budget = 5000;
    int k = 0;
    bit ph = 1'b0;
    bit hold = 1'b0;
    logic [7:0] held = '0;
    rd_cycles = 0;
    while (exp_q.size() > 0 && budget > 0) begin
      if (hold) check({tag, "_hold"}, rd_data, held);
      rd_ready = tog ? ~ph : 1'b1;
      ph = ~ph;
      hold = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          check(tag, rd_data, exp_q.pop_front());
          check({tag, "_last"}, rd_last, (k % 512) == 511);
          k++;
        end else begin
          hold = 1'b1;
          held = rd_data;
        end
      end
      @(negedge clk);
      budget--;
      rd_cycles++;
    end
    rd_ready = 1'b0;
    check({tag, "_rd_left"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_abort = 1'b0; rd_ready = 1'b0;
    @(negedge clk);

    // 1: reset state, single sector, latency and back-to-back drain
    do_reset();
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_banks_full", banks_full, 0);
    for (int i = 0; i < 512; i++) wr_q.push_back(8'(i));
    rd_ready = 1'b1;
    write_q("t1");
    check("t1_banks_full", banks_full, 1);
    check("t1_valid_e1", rd_valid, 0);
    @(negedge clk);
    check("t1_valid_e2", rd_valid, 0);
    @(negedge clk);
    check("t1_valid_e3", rd_valid, 1);
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
    read_q(1'b0, "t1_data");
    check("t1_cycles", rd_cycles, 512);
    check("t1_end_valid", rd_valid, 0);
    check("t1_end_full", banks_full, 0);

    // 2: both banks full, held write lands at bank 0 addr 0 after release
    do_reset();
    for (int i = 0; i < 512; i++) wr_q.push_back(8'(i));
    for (int i = 0; i < 512; i++) wr_q.push_back(8'(255 - (i % 256)));
    write_q("t2");
    check("t2_banks_full", banks_full, 2);
    check("t2_wr_ready", wr_ready, 0);
    check("t2_rd_valid", rd_valid, 1);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_stall", wr_ready, 0);
      check("t2_head", rd_data, 8'h00);
    end
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
    read_q(1'b0, "t2_b0");
    check("t2_rel_ready", wr_ready, 1);
    check("t2_rel_full", banks_full, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(255 - (i % 256)));
    read_q(1'b0, "t2_b1");
    for (int i = 0; i < 511; i++) wr_q.push_back(8'h11);
    write_q("t2_fill");
    check("t2_fill_full", banks_full, 1);
    exp_q.push_back(8'h77);
    for (int i = 0; i < 511; i++) exp_q.push_back(8'h11);
    read_q(1'b0, "t2_b0b");

    // 3: abort discards a partial sector, including a word offered with the abort
    do_reset();
    for (int i = 0; i < 100; i++) wr_q.push_back(8'h5A);
    write_q("t3_part");
    wr_valid = 1'b1; wr_data = 8'hEE; wr_abort = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; wr_abort = 1'b0;
    check("t3_abort_full", banks_full, 0);
    for (int i = 0; i < 512; i++) wr_q.push_back(8'hA5);
    write_q("t3");
    check("t3_full", banks_full, 1);
    for (int i = 0; i < 512; i++) exp_q.push_back(8'hA5);
    read_q(1'b0, "t3_data");
    repeat (3) @(negedge clk);
    check("t3_end_full", banks_full, 0);
    check("t3_end_valid", rd_valid, 0);

    // 4: toggling rd_ready on bank 0 while bank 1 fills
    do_reset();
    for (int i = 0; i < 512; i++) wr_q.push_back(8'(i) ^ 8'hC3);
    write_q("t4_a");
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i) ^ 8'hC3);
    for (int i = 0; i < 512; i++) wr_q.push_back(~8'(i));
    fork
      write_q("t4_b");
      read_q(1'b1, "t4_ra");
    join
    for (int i = 0; i < 512; i++) exp_q.push_back(~8'(i));
    read_q(1'b0, "t4_rb");

    // 5: reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 512; i++) wr_q.push_back(8'(i));
    write_q("t5");
    for (int i = 0; i < 300; i++) exp_q.push_back(8'(i));
    read_q(1'b0, "t5_part");
    check("t5_word300", rd_data, 8'(300));
    rst = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", rd_valid, 0);
    check("t5_rst_full", banks_full, 0);
    check("t5_rst_ready", wr_ready, 1);
    rst = 1'b0;
    rd_ready = 1'b0;
    for (int i = 0; i < 512; i++) wr_q.push_back(8'(i) ^ 8'h99);
    write_q("t5_new");
    check("t5_new_full", banks_full, 1);
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i) ^ 8'h99);
    read_q(1'b0, "t5_new_data");

    // 6: bank 1 commit in the same cycle bank 0 releases
    do_reset();
    for (int i = 0; i < 512; i++) wr_q.push_back(8'(i));
    write_q("t6_a");
    for (int i = 0; i < 511; i++) wr_q.push_back(8'(i) ^ 8'h5A);
    write_q("t6_b");
    for (int i = 0; i < 511; i++) exp_q.push_back(8'(i));
    read_q(1'b0, "t6_ra");
    check("t6_pre_last", rd_last, 1);
    check("t6_pre_data", rd_data, 8'hFF);
    wr_valid = 1'b1; wr_data = 8'hA5; rd_ready = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; rd_ready = 1'b0;
    check("t6_full", banks_full, 1);
    check("t6_valid_e1", rd_valid, 0);
    check("t6_wr_ready", wr_ready, 1);
    @(negedge clk);
    check("t6_valid_e2", rd_valid, 0);
    @(negedge clk);
    check("t6_valid_e3", rd_valid, 1);
    check("t6_b_word0", rd_data, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
